// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch flushes, data-memory waits with timeout.
// Optional cycle counters are built only when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] id_rsaddr_i,
    input  logic [4:0] id_rtaddr_i,
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rtaddr_i,
    input  logic       branch_taken_i,
    input  logic       dmem_req_i,
    input  logic       dmem_ack_i,
    output logic       pc_write_o,
    output logic       ifid_write_o,
    output logic       ifid_flush_o,
    output logic       idex_write_o,
    output logic       idex_flush_o,
    output logic       exmem_write_o,
    output logic       memwb_bubble_o,
    output logic [1:0] state_o,
`ifdef PIPE_HAZARD_PERF_EN
    output logic [31:0] loaduse_cnt_o,
    output logic [31:0] memstall_cnt_o,
    output logic [31:0] flush_cnt_o,
`endif
    output logic       err_o
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1
    } state_e;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             hz;
    logic             mem_pending;
    logic             freeze;

    always_comb begin
        hz = ex_memread_i && (ex_rtaddr_i != 5'd0) &&
             ((ex_rtaddr_i == id_rsaddr_i) || (ex_rtaddr_i == id_rtaddr_i));
        // A dropped request without ack releases exactly like an ack.
        mem_pending = dmem_req_i && !dmem_ack_i;
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        freeze  = 1'b0;
        case (state_q)
            ST_MEMWAIT: begin
                if (!mem_pending) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    freeze = 1'b1;
                    if (cnt_q == TIMEOUT_LAST) begin
                        err_d   = 1'b1;
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                if (mem_pending) begin
                    freeze  = 1'b1;
                    state_d = ST_MEMWAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        pc_write_o     = 1'b1;
        ifid_write_o   = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_write_o   = 1'b1;
        idex_flush_o   = 1'b0;
        exmem_write_o  = 1'b1;
        memwb_bubble_o = 1'b0;
        if (rst_i) begin
            pc_write_o     = 1'b0;
            ifid_write_o   = 1'b0;
            idex_write_o   = 1'b0;
            exmem_write_o  = 1'b0;
            ifid_flush_o   = 1'b1;
            idex_flush_o   = 1'b1;
            memwb_bubble_o = 1'b1;
        end else if (freeze) begin
            pc_write_o     = 1'b0;
            ifid_write_o   = 1'b0;
            idex_write_o   = 1'b0;
            exmem_write_o  = 1'b0;
            memwb_bubble_o = 1'b1;
        end else if (hz) begin
            // Branch is held off; it is re-evaluated once the load has moved on.
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
        end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign state_o = state_q;
    assign err_o   = err_q;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] loaduse_q, loaduse_d;
    logic [31:0] memstall_q, memstall_d;
    logic [31:0] flush_q, flush_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        sat_inc = (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    always_comb begin
        loaduse_d  = sat_inc(loaduse_q, !freeze && hz);
        memstall_d = sat_inc(memstall_q, freeze);
        flush_d    = sat_inc(flush_q, ifid_flush_o);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            loaduse_q  <= '0;
            memstall_q <= '0;
            flush_q    <= '0;
        end else begin
            loaduse_q  <= loaduse_d;
            memstall_q <= memstall_d;
            flush_q    <= flush_d;
        end
    end

    assign loaduse_cnt_o  = loaduse_q;
    assign memstall_cnt_o = memstall_q;
    assign flush_cnt_o    = flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed steps then random traffic against a cycle-level reference model.
// Perf counters are checked too when PIPE_HAZARD_PERF_EN is defined.
module tb_pipe_hazard_ctrl;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [4:0] id_rsaddr_i = '0;
    logic [4:0] id_rtaddr_i = '0;
    logic       ex_memread_i = 1'b0;
    logic [4:0] ex_rtaddr_i = '0;
    logic       branch_taken_i = 1'b0;
    logic       dmem_req_i = 1'b0;
    logic       dmem_ack_i = 1'b0;
    logic       pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_flush_o;
    logic       exmem_write_o, memwb_bubble_o, err_o;
    logic [1:0] state_o;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] loaduse_cnt_o, memstall_cnt_o, flush_cnt_o;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: whether a memory wait episode is open, how many freeze cycles it has used, sticky error.
    bit m_wait;
    int m_frz;
    bit m_err;
    int m_lu, m_ms, m_fl;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(16)) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .id_rsaddr_i(id_rsaddr_i),
        .id_rtaddr_i(id_rtaddr_i),
        .ex_memread_i(ex_memread_i),
        .ex_rtaddr_i(ex_rtaddr_i),
        .branch_taken_i(branch_taken_i),
        .dmem_req_i(dmem_req_i),
        .dmem_ack_i(dmem_ack_i),
        .pc_write_o(pc_write_o),
        .ifid_write_o(ifid_write_o),
        .ifid_flush_o(ifid_flush_o),
        .idex_write_o(idex_write_o),
        .idex_flush_o(idex_flush_o),
        .exmem_write_o(exmem_write_o),
        .memwb_bubble_o(memwb_bubble_o),
        .state_o(state_o),
`ifdef PIPE_HAZARD_PERF_EN
        .loaduse_cnt_o(loaduse_cnt_o),
        .memstall_cnt_o(memstall_cnt_o),
        .flush_cnt_o(flush_cnt_o),
`endif
        .err_o(err_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wait = 0; m_frz = 0; m_err = 0;
        m_lu = 0; m_ms = 0; m_fl = 0;
    endtask

    task automatic check_perf();
`ifdef PIPE_HAZARD_PERF_EN
        check("loaduse_cnt", loaduse_cnt_o, m_lu);
        check("memstall_cnt", memstall_cnt_o, m_ms);
        check("flush_cnt", flush_cnt_o, m_fl);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc_write"}, {31'd0, pc_write_o}, 0);
        check({tag, "_ifid_write"}, {31'd0, ifid_write_o}, 0);
        check({tag, "_idex_write"}, {31'd0, idex_write_o}, 0);
        check({tag, "_exmem_write"}, {31'd0, exmem_write_o}, 0);
        check({tag, "_ifid_flush"}, {31'd0, ifid_flush_o}, 1);
        check({tag, "_idex_flush"}, {31'd0, idex_flush_o}, 1);
        check({tag, "_memwb_bubble"}, {31'd0, memwb_bubble_o}, 1);
        check({tag, "_state"}, {30'd0, state_o}, 0);
        check({tag, "_err"}, {31'd0, err_o}, 0);
        check_perf();
    endtask

    // One clock cycle: drive, check the Mealy outputs mid-cycle, then advance the model on the edge.
    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                        input logic [4:0] ert, input logic br, input logic req, input logic ack);
        bit hz, frz, e_ifid_flush;
        @(negedge clk);
        rst_i = 1'b0;
        id_rsaddr_i = rs; id_rtaddr_i = rt; ex_memread_i = mr;
        ex_rtaddr_i = ert; branch_taken_i = br; dmem_req_i = req; dmem_ack_i = ack;
        #1;
        hz  = mr && (ert != 0) && (ert == rs || ert == rt);
        frz = req && !ack;
        e_ifid_flush = !frz && !hz && br;
        check("pc_write", {31'd0, pc_write_o}, {31'd0, !(frz || hz)});
        check("ifid_write", {31'd0, ifid_write_o}, {31'd0, !(frz || hz)});
        check("idex_write", {31'd0, idex_write_o}, {31'd0, !frz});
        check("exmem_write", {31'd0, exmem_write_o}, {31'd0, !frz});
        check("memwb_bubble", {31'd0, memwb_bubble_o}, {31'd0, frz});
        check("idex_flush", {31'd0, idex_flush_o}, {31'd0, !frz && hz});
        check("ifid_flush", {31'd0, ifid_flush_o}, {31'd0, e_ifid_flush});
        check("state", {30'd0, state_o}, {31'd0, m_wait});
        check("err", {31'd0, err_o}, {31'd0, m_err});
        check_perf();
        @(posedge clk);
        if (frz) begin
            m_frz++;
            if (m_frz == T) begin
                m_err = 1; m_wait = 0; m_frz = 0;
            end else begin
                m_wait = 1;
            end
        end else begin
            m_wait = 0; m_frz = 0;
        end
        if (!frz && hz) m_lu++;
        if (frz) m_ms++;
        if (e_ifid_flush) m_fl++;
    endtask

    task automatic idle();
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Raise reset between edges; outputs must react with no clock edge in between.
    task automatic async_reset(input string tag);
        #3;
        rst_i = 1'b1;
        #1;
        model_reset();
        check_reset_outputs(tag);
    endtask

    initial begin
        model_reset();
        #1;
        check_reset_outputs("por");

        // Load-use stall, then defaults, then register 0 never hazards.
        step(5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        idle();
        step(5'd8, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step(5'd2, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        step(5'd2, 5'd9, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);

        // Branch alone flushes; branch under a hazard stalls instead.
        step(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        step(5'd8, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        step(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);

        // Multi-cycle access: three frozen cycles then the ack cycle.
        repeat (3) step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step(5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b1);
        idle();
        // Single-cycle access and a dropped request.
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);

        // Timeout: T frozen cycles, then error stays set.
        repeat (T) step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        repeat (3) idle();
        step(5'd4, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a wait clears everything at once.
        repeat (2) step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        async_reset("mid_wait");
        @(posedge clk);
        #1;
        check_reset_outputs("held");
        idle();
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                async_reset("rand_rst");
            end
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
